// File: rtl/nf10_10g_tx_pkg.sv
// Shared definitions for the 10G transmit packet queue.
// Holds tuser field offsets, ingress FSM states and buffer word layout.
package nf10_10g_tx_pkg;

  localparam int LEN_LO  = 0;
  localparam int SRC_LO  = 16;
  localparam int DST_LO  = 24;
  localparam int FIELD_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_DISCARD
  } in_state_e;

  // Buffer word is {tlast, tstrb, tdata}
  function automatic int word_w(int dw);
    return dw + dw / 8 + 1;
  endfunction

  function automatic int strb_lo(int dw);
    return dw;
  endfunction

  function automatic int last_bit(int dw);
    return dw + dw / 8;
  endfunction

endpackage

// File: rtl/nf10_sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// Contents are not reset; only the pointers around it are.
module nf10_sdp_ram
  import nf10_10g_tx_pkg::*;
#(
  parameter int WIDTH      = 73,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/nf10_10g_tx_pkt_queue.sv
// Store-and-forward egress queue in front of a 10G MAC transmit port.
// Whole packets are buffered; rejected or overflowing packets are dropped.
module nf10_10g_tx_pkt_queue
  import nf10_10g_tx_pkg::*;
#(
  parameter int          C_DATA_WIDTH     = 64,
  parameter int          C_TUSER_WIDTH    = 128,
  parameter int          C_DEPTH_LOG2     = 9,
  parameter int          C_PKT_DEPTH_LOG2 = 5,
  parameter logic [7:0]  C_DST_PORT_MASK  = 8'h40
) (
  input  logic                       axi_aclk,
  input  logic                       axi_resetn,
  input  logic [C_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  output logic [C_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic [31:0]                drop_count
);

  localparam int SW = C_DATA_WIDTH / 8;
  localparam int WW = word_w(C_DATA_WIDTH);
  localparam int LB = last_bit(C_DATA_WIDTH);
  localparam int SL = strb_lo(C_DATA_WIDTH);
  localparam int DL = C_DEPTH_LOG2;
  localparam int PL = C_PKT_DEPTH_LOG2;
  localparam int UW = C_TUSER_WIDTH;
  localparam logic [DL:0] FULL = {1'b1, {DL{1'b0}}};

  in_state_e state_q, state_n;

  logic          ready_q;
  logic [DL:0]   wr_ptr, wr_commit, rd_ptr, used;
  logic [PL:0]   pkt_cnt;
  logic [PL-1:0] mwr_ptr, mhd_ptr, mhd_eff;
  logic [UW-1:0] tuser_q, meta_wdata, meta_rdata;
  logic [31:0]   drop_q;
  logic [WW-1:0] wr_word, rd_word;

  logic beat, dst_ok, meta_full, data_full;
  logic wr_en, commit, drop, rewind, latch_user;
  logic rd_en, rvalid, pop, pop_last;
  logic [1:0] occ;

  logic [1:0]    sk_cnt;
  logic [WW-1:0] sk0_word, sk1_word;
  logic [UW-1:0] sk0_user, sk1_user;

  assign beat      = s_axis_tvalid & ready_q;
  assign dst_ok    = |(s_axis_tuser[DST_LO +: FIELD_W] & C_DST_PORT_MASK);
  assign meta_full = pkt_cnt[PL];
  assign used      = wr_ptr - rd_ptr;
  assign data_full = (used == FULL);
  assign wr_word   = {s_axis_tlast, s_axis_tstrb, s_axis_tdata};

  always_comb begin
    state_n    = state_q;
    wr_en      = 1'b0;
    commit     = 1'b0;
    drop       = 1'b0;
    rewind     = 1'b0;
    latch_user = 1'b0;
    meta_wdata = tuser_q;
    unique case (state_q)
      ST_IDLE: begin
        if (beat) begin
          meta_wdata = s_axis_tuser;
          if (!dst_ok || meta_full || data_full) begin
            drop = 1'b1;
            if (!s_axis_tlast) state_n = ST_DISCARD;
          end else begin
            wr_en      = 1'b1;
            latch_user = 1'b1;
            if (s_axis_tlast) commit = 1'b1;
            else state_n = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (beat) begin
          if (data_full) begin
            drop    = 1'b1;
            rewind  = 1'b1;
            state_n = s_axis_tlast ? ST_IDLE : ST_DISCARD;
          end else begin
            wr_en = 1'b1;
            if (s_axis_tlast) begin
              commit  = 1'b1;
              state_n = ST_IDLE;
            end
          end
        end
      end
      ST_DISCARD: begin
        if (beat && s_axis_tlast) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      ready_q   <= 1'b0;
      state_q   <= ST_IDLE;
      wr_ptr    <= '0;
      wr_commit <= '0;
      mwr_ptr   <= '0;
      tuser_q   <= '0;
      drop_q    <= '0;
      pkt_cnt   <= '0;
    end else begin
      ready_q <= 1'b1;
      state_q <= state_n;
      if (rewind) wr_ptr <= wr_commit;
      else if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (commit) begin
        wr_commit <= wr_ptr + 1'b1;
        mwr_ptr   <= mwr_ptr + 1'b1;
      end
      if (latch_user) tuser_q <= s_axis_tuser;
      if (drop && drop_q != '1) drop_q <= drop_q + 1;
      if (commit && !pop_last) pkt_cnt <= pkt_cnt + 1'b1;
      else if (!commit && pop_last) pkt_cnt <= pkt_cnt - 1'b1;
    end
  end

  assign pop      = (sk_cnt != 2'd0) & m_axis_tready;
  assign pop_last = pop & sk0_word[LB];
  assign occ      = sk_cnt + {1'b0, rvalid};

  // Keep skid plus in-flight read within two entries
  assign rd_en = (rd_ptr != wr_commit) && (pkt_cnt != '0) &&
                 ((occ < 2'd2) || (occ == 2'd2 && pop));

  // A tlast coming out of the RAM moves the metadata head for the next read
  assign mhd_eff = mhd_ptr + PL'(rvalid & rd_word[LB]);

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      rd_ptr   <= '0;
      mhd_ptr  <= '0;
      rvalid   <= 1'b0;
      sk_cnt   <= 2'd0;
      sk0_word <= '0;
      sk1_word <= '0;
      sk0_user <= '0;
      sk1_user <= '0;
    end else begin
      rvalid  <= rd_en;
      mhd_ptr <= mhd_eff;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (pop) begin
        if (rvalid) begin
          if (sk_cnt == 2'd2) begin
            sk0_word <= sk1_word;
            sk0_user <= sk1_user;
            sk1_word <= rd_word;
            sk1_user <= meta_rdata;
          end else begin
            sk0_word <= rd_word;
            sk0_user <= meta_rdata;
          end
        end else begin
          sk0_word <= sk1_word;
          sk0_user <= sk1_user;
          sk_cnt   <= sk_cnt - 2'd1;
        end
      end else if (rvalid) begin
        if (sk_cnt == 2'd0) begin
          sk0_word <= rd_word;
          sk0_user <= meta_rdata;
        end else begin
          sk1_word <= rd_word;
          sk1_user <= meta_rdata;
        end
        sk_cnt <= sk_cnt + 2'd1;
      end
    end
  end

  assign s_axis_tready = ready_q;
  assign m_axis_tvalid = (sk_cnt != 2'd0);
  assign m_axis_tdata  = sk0_word[C_DATA_WIDTH-1:0];
  assign m_axis_tstrb  = sk0_word[SL +: SW];
  assign m_axis_tlast  = sk0_word[LB];
  assign m_axis_tuser  = sk0_user;
  assign drop_count    = drop_q;

  nf10_sdp_ram #(
    .WIDTH      (WW),
    .DEPTH_LOG2 (DL)
  ) u_data_ram (
    .clk     (axi_aclk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[DL-1:0]),
    .wr_data (wr_word),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr[DL-1:0]),
    .rd_data (rd_word)
  );

  nf10_sdp_ram #(
    .WIDTH      (UW),
    .DEPTH_LOG2 (PL)
  ) u_meta_ram (
    .clk     (axi_aclk),
    .wr_en   (commit),
    .wr_addr (mwr_ptr),
    .wr_data (meta_wdata),
    .rd_en   (rd_en),
    .rd_addr (mhd_eff),
    .rd_data (meta_rdata)
  );

endmodule

// File: tb/tb_nf10_10g_tx_pkt_queue.sv
// Directed and random bench for the 10G transmit packet queue.
// Expected beats are queued at ingress and matched at egress.
module tb_nf10_10g_tx_pkt_queue;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [63:0]  s_tdata = '0;
  logic [7:0]   s_tstrb = '0;
  logic [127:0] s_tuser = '0;
  logic         s_tvalid = 1'b0;
  logic         s_tready;
  logic         s_tlast = 1'b0;
  logic [63:0]  m_tdata;
  logic [7:0]   m_tstrb;
  logic [127:0] m_tuser;
  logic         m_tvalid;
  logic         m_tready = 1'b0;
  logic         m_tlast;
  logic [31:0]  drop_count;

  typedef struct packed {
    logic [127:0] user;
    logic         last;
    logic [7:0]   strb;
    logic [63:0]  data;
  } beat_t;

  beat_t sb[$];
  beat_t mon_got, mon_exp;
  int    checks = 0;
  int    errors = 0;
  int    exp_drops = 0;
  bit    rand_on = 1'b0;

  always #5 clk = ~clk;

  nf10_10g_tx_pkt_queue dut (
    .axi_aclk      (clk),
    .axi_resetn    (rst_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tstrb  (s_tstrb),
    .s_axis_tuser  (s_tuser),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tstrb  (m_tstrb),
    .m_axis_tuser  (m_tuser),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .drop_count    (drop_count)
  );

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && m_tvalid && m_tready) begin
      mon_got = {m_tuser, m_tlast, m_tstrb, m_tdata};
      mon_exp = (sb.size() != 0) ? sb.pop_front() : 'x;
      chk("egress_beat", mon_got, mon_exp);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic [7:0] dst, input int len,
                          input bit ok);
    beat_t b;
    logic [127:0] user;
    user = {$urandom, $urandom, $urandom, dst, 8'h01, 16'(len * 8)};
    for (int i = 0; i < len; i++) begin
      b.user = user;
      b.last = (i == len - 1);
      b.strb = b.last ? (8'hff >> $urandom_range(0, 7)) : 8'hff;
      b.data = {$urandom, $urandom};
      s_tuser  = (i == 0) ? user : 128'($urandom);
      s_tdata  = b.data;
      s_tstrb  = b.strb;
      s_tlast  = b.last;
      s_tvalid = 1'b1;
      if (ok) sb.push_back(b);
      tick();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 5000) begin
      tick();
      n++;
    end
    chk(tag, sb.size(), 0);
    repeat (10) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) tick();
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_drop", drop_count, 0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", s_tready, 1);

    m_tready = 1'b1;
    send_pkt(8'h40, 8, 1'b1);
    chk("lat_t0", m_tvalid, 0);
    tick();
    chk("lat_t1", m_tvalid, 0);
    tick();
    chk("lat_t2", m_tvalid, 1);
    wait_drain("drain_8beat");
    chk("drop_8beat", drop_count, exp_drops);

    send_pkt(8'h01, 5, 1'b0);
    exp_drops++;
    send_pkt(8'h40, 3, 1'b1);
    wait_drain("drain_dst");
    chk("drop_dst", drop_count, exp_drops);

    m_tready = 1'b0;
    send_pkt(8'h40, 600, 1'b0);
    exp_drops++;
    repeat (5) tick();
    chk("drop_overflow", drop_count, exp_drops);
    chk("no_egress_overflow", m_tvalid, 0);
    send_pkt(8'h40, 4, 1'b1);
    m_tready = 1'b1;
    wait_drain("drain_after_ovf");

    m_tready = 1'b0;
    for (int i = 0; i < 33; i++) send_pkt(8'h40, 1, i < 32);
    exp_drops++;
    tick();
    chk("drop_meta_full", drop_count, exp_drops);
    m_tready = 1'b1;
    wait_drain("drain_singles");

    rand_on = 1'b1;
    fork
      begin
        for (int p = 0; p < 100; p++) begin
          logic [7:0] dst;
          dst = 8'($urandom);
          send_pkt(dst, $urandom_range(1, 8), dst[6]);
          if (!dst[6]) exp_drops++;
          repeat ($urandom_range(0, 3)) tick();
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          tick();
          m_tready = ($urandom_range(0, 4) != 0);
        end
      end
    join
    m_tready = 1'b1;
    wait_drain("drain_random");
    chk("drop_random", drop_count, exp_drops);

    m_tready = 1'b0;
    send_pkt(8'h40, 3, 1'b1);
    s_tuser  = {96'h0, 8'h40, 8'h01, 16'd32};
    s_tdata  = 64'h1234;
    s_tstrb  = 8'hff;
    s_tvalid = 1'b1;
    repeat (2) tick();
    chk("pre_rst_tvalid", m_tvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_s_tready", s_tready, 0);
    chk("mid_rst_m_tvalid", m_tvalid, 0);
    chk("mid_rst_m_tdata", m_tdata, 0);
    chk("mid_rst_m_tuser", m_tuser, 0);
    chk("mid_rst_drop", drop_count, 0);
    sb.delete();
    exp_drops = 0;
    s_tvalid  = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    m_tready = 1'b1;
    send_pkt(8'h40, 5, 1'b1);
    wait_drain("drain_after_rst");
    chk("drop_after_rst", drop_count, exp_drops);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
